// File: rtl/vote_filter.sv
// ---------------------------------------------------------------------------
// vote_filter
//
// Purpose:
//   N-input majority/minority voter with a registered popcount and a
//   persistence (deglitch) filter on the vote output.
//   - Stage 1 registers the popcount of d and the raw vote.
//   - Stage 2 lets y follow the raw vote only after the two have disagreed
//     for HOLD consecutive enabled cycles.
//   Typical uses are redundant-sensor voting and conditioning inputs ahead
//   of control FSMs.
//
// Parameters:
//   N     number of voter inputs (odd, 3..15)
//   HOLD  consecutive enabled cycles of disagreement before y changes (1..255)
//   CW    width of count, derived as $clog2(N+1)
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset_n  in   1   asynchronous active-low reset
//   en       in   1   cycle enable; when low, all state freezes
//   mode     in   1   0 = majority, 1 = minority
//   d        in   N   voter inputs
//   y        out  1   filtered vote (registered)
//   count    out  CW  registered popcount of d
//   changed  out  1   single-cycle pulse on the cycle y takes a new value
//   stable   out  1   high when no disagreement is pending
// ---------------------------------------------------------------------------
module vote_filter #(
  parameter int N    = 3,
  parameter int HOLD = 4,
  localparam int CW  = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          mode,
  input  logic [N-1:0]  d,
  output logic          y,
  output logic [CW-1:0] count,
  output logic          changed,
  output logic          stable
);

  // Pending counter only has to reach HOLD-1, so it never needs more than
  // $clog2(HOLD) bits; HOLD=1 still gets a one-bit register that stays 0.
  localparam int PW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [CW-1:0] HALF    = CW'(N / 2);
  localparam logic [PW-1:0] HOLD_M1 = PW'(HOLD - 1);

  // Reject illegal configurations at elaboration time.
  generate
    if ((N < 3) || (N > 15) || ((N % 2) == 0)) begin : g_bad_n
      $error("vote_filter: N must be odd and in 3..15");
    end
    if ((HOLD < 1) || (HOLD > 255)) begin : g_bad_hold
      $error("vote_filter: HOLD must be in 1..255");
    end
  endgenerate

  logic [CW-1:0] count_q, count_d;
  logic          raw_q,   raw_d;
  logic          y_q,     y_d;
  logic [PW-1:0] pend_q,  pend_d;
  logic          changed_q, changed_d;
  logic [CW-1:0] pop;

  // Popcount of the voter inputs.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + CW'(d[i]);
    end
  end

  // Stage 1: N is odd so there are no ties, and minority is simply the
  // complement of majority.
  always_comb begin
    count_d = count_q;
    raw_d   = raw_q;
    if (en) begin
      count_d = pop;
      raw_d   = (pop > HALF) ^ mode;
    end
  end

  // Stage 2: persistence filter. Any agreeing edge clears pend, so a
  // disagreement must be uninterrupted to reach y. A disabled edge holds
  // everything except changed, which drops so a pulse lasts one cycle.
  always_comb begin
    y_d       = y_q;
    pend_d    = pend_q;
    changed_d = 1'b0;
    if (en) begin
      if (raw_q == y_q) begin
        pend_d = '0;
      end else if (pend_q == HOLD_M1) begin
        y_d       = raw_q;
        pend_d    = '0;
        changed_d = 1'b1;
      end else begin
        pend_d = pend_q + PW'(1);
      end
    end
  end

  // State registers for both stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      raw_q     <= 1'b0;
      y_q       <= 1'b0;
      pend_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      raw_q     <= raw_d;
      y_q       <= y_d;
      pend_q    <= pend_d;
      changed_q <= changed_d;
    end
  end

  assign y       = y_q;
  assign count   = count_q;
  assign changed = changed_q;
  assign stable  = (pend_q == '0);

endmodule

// File: tb/tb_vote_filter.sv
// ---------------------------------------------------------------------------
// tb_vote_filter
//
// Purpose:
//   Directed, self-checking bench for vote_filter. dut_a is N=3/HOLD=4 and
//   dut_b is N=5/HOLD=1. The stimulus process pushes the hand-computed
//   expected outputs for each upcoming edge into a scoreboard queue, and a
//   separate monitor pops and compares them after the edge. Asynchronous
//   reset checks go through a second queue, triggered by an event.
// ---------------------------------------------------------------------------
module tb_vote_filter;

  typedef struct {
    bit          sel;
    bit          drain;
    logic        y;
    logic [3:0]  count;
    logic        changed;
    logic        stable;
    string       tag;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       mode;
  logic [2:0] d_a;
  logic [4:0] d_b;
  logic       y_a, y_b;
  logic [1:0] count_a;
  logic [2:0] count_b;
  logic       changed_a, changed_b;
  logic       stable_a, stable_b;

  exp_t sb[$];
  exp_t aq[$];
  event async_ev;

  int n_checks = 0;
  int n_fail   = 0;

  vote_filter #(.N(3), .HOLD(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .d(d_a),
    .y(y_a), .count(count_a), .changed(changed_a), .stable(stable_a)
  );

  vote_filter #(.N(5), .HOLD(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .d(d_b),
    .y(y_b), .count(count_b), .changed(changed_b), .stable(stable_b)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison; only the monitor calls this.
  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: after each rising edge compare against the scoreboard head;
  // on an async request compare the pending asynchronous expectations.
  always @(posedge clk or async_ev) begin
    exp_t e;
    #1;
    if (aq.size() > 0) begin
      while (aq.size() > 0) begin
        e = aq.pop_front();
        if (e.drain) begin
          checkOutput({e.tag, ".leftover"}, sb.size(), 0);
        end else begin
          checkOutput({e.tag, ".y"},       e.sel ? int'(y_b) : int'(y_a), int'(e.y));
          checkOutput({e.tag, ".count"},   e.sel ? int'(count_b) : int'(count_a), int'(e.count));
          checkOutput({e.tag, ".changed"}, e.sel ? int'(changed_b) : int'(changed_a), int'(e.changed));
          checkOutput({e.tag, ".stable"},  e.sel ? int'(stable_b) : int'(stable_a), int'(e.stable));
        end
      end
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.tag, ".y"},       e.sel ? int'(y_b) : int'(y_a), int'(e.y));
      checkOutput({e.tag, ".count"},   e.sel ? int'(count_b) : int'(count_a), int'(e.count));
      checkOutput({e.tag, ".changed"}, e.sel ? int'(changed_b) : int'(changed_a), int'(e.changed));
      checkOutput({e.tag, ".stable"},  e.sel ? int'(stable_b) : int'(stable_a), int'(e.stable));
    end
  end

  // Drive inputs for the next edge and record what must follow it.
  task automatic applyStimulus(input bit sel, input logic e, input logic m,
                               input logic [4:0] dv, input logic ey,
                               input logic [3:0] ec, input logic ech,
                               input logic est, input string tag);
    exp_t x;
    @(negedge clk);
    en   = e;
    mode = m;
    if (sel) d_b = dv;
    else     d_a = dv[2:0];
    x.sel = sel; x.drain = 1'b0; x.y = ey; x.count = ec;
    x.changed = ech; x.stable = est; x.tag = tag;
    sb.push_back(x);
  endtask

  // Quiet reset between scenarios; en low so the idle edge afterwards
  // leaves the reset state untouched.
  task automatic doReset();
    @(negedge clk);
    en      = 1'b0;
    mode    = 1'b0;
    d_a     = '0;
    d_b     = '0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // Asynchronous reset pulse between edges with an immediate check.
  task automatic pulseReset(input string tag);
    exp_t x;
    #1;
    reset_n = 1'b0;
    x.sel = 1'b0; x.drain = 1'b0; x.y = 1'b0; x.count = 4'd0;
    x.changed = 1'b0; x.stable = 1'b1; x.tag = tag;
    aq.push_back(x);
    -> async_ev;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    exp_t x;
    reset_n = 1'b1;
    en      = 1'b0;
    mode    = 1'b0;
    d_a     = '0;
    d_b     = '0;
    #1;
    reset_n = 1'b0;
    x.drain = 1'b0; x.y = 1'b0; x.count = 4'd0; x.changed = 1'b0; x.stable = 1'b1;
    x.sel = 1'b0; x.tag = "rst_a"; aq.push_back(x);
    x.sel = 1'b1; x.tag = "rst_b"; aq.push_back(x);
    -> async_ev;
    @(negedge clk);
    reset_n = 1'b1;

    // Majority, d=011 held: y rises at the fifth edge.
    $display("[TB] majority latency");
    applyStimulus(0, 1, 0, 5'b000, 0, 0, 0, 1, "t1_idle");
    applyStimulus(0, 1, 0, 5'b011, 0, 2, 0, 1, "t1_e1");
    applyStimulus(0, 1, 0, 5'b011, 0, 2, 0, 0, "t1_e2");
    applyStimulus(0, 1, 0, 5'b011, 0, 2, 0, 0, "t1_e3");
    applyStimulus(0, 1, 0, 5'b011, 0, 2, 0, 0, "t1_e4");
    applyStimulus(0, 1, 0, 5'b011, 1, 2, 1, 1, "t1_e5");
    applyStimulus(0, 1, 0, 5'b011, 1, 2, 0, 1, "t1_e6");

    // Return y to 0, then a three-cycle glitch that must be rejected.
    $display("[TB] glitch rejection");
    applyStimulus(0, 1, 0, 5'b000, 1, 0, 0, 1, "t2_f1");
    applyStimulus(0, 1, 0, 5'b000, 1, 0, 0, 0, "t2_f2");
    applyStimulus(0, 1, 0, 5'b000, 1, 0, 0, 0, "t2_f3");
    applyStimulus(0, 1, 0, 5'b000, 1, 0, 0, 0, "t2_f4");
    applyStimulus(0, 1, 0, 5'b000, 0, 0, 1, 1, "t2_f5");
    applyStimulus(0, 1, 0, 5'b110, 0, 2, 0, 1, "t2_g1");
    applyStimulus(0, 1, 0, 5'b110, 0, 2, 0, 0, "t2_g2");
    applyStimulus(0, 1, 0, 5'b110, 0, 2, 0, 0, "t2_g3");
    applyStimulus(0, 1, 0, 5'b000, 0, 0, 0, 0, "t2_g4");
    applyStimulus(0, 1, 0, 5'b000, 0, 0, 0, 1, "t2_g5");
    applyStimulus(0, 1, 0, 5'b000, 0, 0, 0, 1, "t2_g6");

    // Minority truth table through the filter.
    $display("[TB] minority mode");
    doReset();
    applyStimulus(0, 1, 1, 5'b000, 0, 0, 0, 1, "t3_a1");
    applyStimulus(0, 1, 1, 5'b000, 0, 0, 0, 0, "t3_a2");
    applyStimulus(0, 1, 1, 5'b000, 0, 0, 0, 0, "t3_a3");
    applyStimulus(0, 1, 1, 5'b000, 0, 0, 0, 0, "t3_a4");
    applyStimulus(0, 1, 1, 5'b000, 1, 0, 1, 1, "t3_a5");
    applyStimulus(0, 1, 1, 5'b111, 1, 3, 0, 1, "t3_b1");
    applyStimulus(0, 1, 1, 5'b111, 1, 3, 0, 0, "t3_b2");
    applyStimulus(0, 1, 1, 5'b111, 1, 3, 0, 0, "t3_b3");
    applyStimulus(0, 1, 1, 5'b111, 1, 3, 0, 0, "t3_b4");
    applyStimulus(0, 1, 1, 5'b111, 0, 3, 1, 1, "t3_b5");
    applyStimulus(0, 1, 1, 5'b100, 0, 1, 0, 1, "t3_c1");
    applyStimulus(0, 1, 1, 5'b100, 0, 1, 0, 0, "t3_c2");
    applyStimulus(0, 1, 1, 5'b100, 0, 1, 0, 0, "t3_c3");
    applyStimulus(0, 1, 1, 5'b100, 0, 1, 0, 0, "t3_c4");
    applyStimulus(0, 1, 1, 5'b100, 1, 1, 1, 1, "t3_c5");
    applyStimulus(0, 1, 1, 5'b100, 1, 1, 0, 1, "t3_c6");

    // Enable toggling: only enabled edges advance the filter.
    $display("[TB] enable gating");
    doReset();
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 1, "t4_c1");
    applyStimulus(0, 0, 0, 5'b111, 0, 3, 0, 1, "t4_c2");
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 0, "t4_c3");
    applyStimulus(0, 0, 0, 5'b111, 0, 3, 0, 0, "t4_c4");
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 0, "t4_c5");
    applyStimulus(0, 0, 0, 5'b111, 0, 3, 0, 0, "t4_c6");
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 0, "t4_c7");
    applyStimulus(0, 0, 0, 5'b111, 0, 3, 0, 0, "t4_c8");
    applyStimulus(0, 1, 0, 5'b111, 1, 3, 1, 1, "t4_c9");
    applyStimulus(0, 0, 0, 5'b111, 1, 3, 0, 1, "t4_c10");
    applyStimulus(0, 0, 0, 5'b000, 1, 3, 0, 1, "t4_c11");

    // Asynchronous reset while a change is pending.
    $display("[TB] reset mid-pending");
    doReset();
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 1, "t5_e1");
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 0, "t5_e2");
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 0, "t5_e3");
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 1, "t5_r1");
    pulseReset("t5_async");
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 0, "t5_r2");
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 0, "t5_r3");
    applyStimulus(0, 1, 0, 5'b111, 0, 3, 0, 0, "t5_r4");
    applyStimulus(0, 1, 0, 5'b111, 1, 3, 1, 1, "t5_r5");
    applyStimulus(0, 1, 0, 5'b111, 1, 3, 0, 1, "t5_r6");

    // N=5, HOLD=1: no filtering beyond the stage-1 register.
    $display("[TB] N=5 HOLD=1");
    doReset();
    applyStimulus(1, 1, 0, 5'b00111, 0, 3, 0, 1, "t6_a1");
    applyStimulus(1, 1, 0, 5'b00111, 1, 3, 1, 1, "t6_a2");
    applyStimulus(1, 1, 0, 5'b00111, 1, 3, 0, 1, "t6_a3");
    applyStimulus(1, 1, 0, 5'b00011, 1, 2, 0, 1, "t6_b1");
    applyStimulus(1, 1, 0, 5'b00011, 0, 2, 1, 1, "t6_b2");
    applyStimulus(1, 1, 0, 5'b00011, 0, 2, 0, 1, "t6_b3");

    // Every scoreboard entry must have been consumed.
    repeat (3) @(posedge clk);
    @(negedge clk);
    x.sel = 1'b0; x.drain = 1'b1; x.tag = "drain";
    aq.push_back(x);
    -> async_ev;
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
